// File: rtl/programmable_clock_gen.sv
// Programmable clock divider with shadowed period/high-time config, rising-edge counter.
// Optional CLKGEN_MATCH_IRQ_EN adds a sticky match interrupt on the edge counter.
module programmable_clock_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] high_i,
  input  logic             cfg_load,
  input  logic             cnt_clr,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] rising_edge_count,
  output logic             cfg_pending
`ifdef CLKGEN_MATCH_IRQ_EN
  ,
  input  logic [CNT_W-1:0] match_val,
  output logic             match_irq
`endif
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_act, high_act, div_sh, high_sh, phase;
  logic [DIV_W-1:0] div_san, high_san;
  logic [CNT_W-1:0] count_inc;
  logic             period_end, start;

  always_comb begin
    div_san = (div_i < TWO) ? TWO : div_i;
    if (high_i == '0)
      high_san = ONE;
    else if (high_i >= div_san)
      high_san = div_san - ONE;
    else
      high_san = high_i;
  end

  assign period_end = (state == RUN) && (phase == div_act - ONE);
  assign count_inc  = rising_edge_count + CNT_W'(1);

  // A period starts either from idle or on the wrap edge, only while en is high.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (period_end) begin
          if (en) start = 1'b1;
          else    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      phase             <= '0;
      clk_out           <= 1'b0;
      rise_pulse        <= 1'b0;
      rising_edge_count <= '0;
      cfg_pending       <= 1'b0;
      div_act           <= TWO;
      high_act          <= ONE;
      div_sh            <= TWO;
      high_sh           <= ONE;
    end else begin
      state      <= state_nxt;
      rise_pulse <= start;

      if (start) begin
        phase   <= '0;
        clk_out <= 1'b1;
        if (cfg_pending) begin
          div_act  <= div_sh;
          high_act <= high_sh;
        end
      end else if (state == RUN && !period_end) begin
        phase   <= phase + ONE;
        clk_out <= (phase + ONE) < high_act;
      end else begin
        phase   <= '0;
        clk_out <= 1'b0;
      end

      // A load on a start edge lands in the shadow after the old shadow was applied.
      if (cfg_load) begin
        div_sh      <= div_san;
        high_sh     <= high_san;
        cfg_pending <= 1'b1;
      end else if (start) begin
        cfg_pending <= 1'b0;
      end

      if (cnt_clr)
        rising_edge_count <= '0;
      else if (start)
        rising_edge_count <= count_inc;
    end
  end

`ifdef CLKGEN_MATCH_IRQ_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      match_irq <= 1'b0;
    else if (cnt_clr)
      match_irq <= 1'b0;
    else if (start && count_inc == match_val)
      match_irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_programmable_clock_gen.sv
// Randomised scoreboard bench: a waveform-queue reference model predicts every output cycle.
module tb_programmable_clock_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] div_i = '0;
  logic [DIV_W-1:0] high_i = '0;
  logic             cfg_load = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             clk_out, rise_pulse, cfg_pending;
  logic [CNT_W-1:0] rising_edge_count;

  programmable_clock_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .div_i            (div_i),
    .high_i           (high_i),
    .cfg_load         (cfg_load),
    .cnt_clr          (cnt_clr),
    .clk_out          (clk_out),
    .rise_pulse       (rise_pulse),
    .rising_edge_count(rising_edge_count),
    .cfg_pending      (cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             co;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic             pend;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: config registers plus the remaining bits of the current period.
  int   s_div = 2, s_high = 1, a_div = 2, a_high = 1, m_cnt = 0;
  bit   m_pend = 0;
  bit   wave[$];

  task automatic step(input bit e, input bit load, input int d, input int h,
                      input bit clr, input bit rst);
    exp_t x;
    bit   start;
    int   sd, sh;
    @(negedge clk);
    en = e; cfg_load = load; div_i = DIV_W'(d); high_i = DIV_W'(h);
    cnt_clr = clr; rst_n = !rst;
    if (rst) begin
      s_div = 2; s_high = 1; a_div = 2; a_high = 1;
      m_pend = 0; m_cnt = 0; wave.delete();
      x = '0;
    end else begin
      start = (wave.size() == 0) && e;
      if (start) begin
        if (m_pend) begin a_div = s_div; a_high = s_high; end
        for (int i = 0; i < a_div; i++) wave.push_back(i < a_high);
      end
      x.co = (wave.size() > 0) ? wave.pop_front() : 1'b0;
      x.rise = start;
      if (load) begin
        sd = (d < 2) ? 2 : d;
        sh = (h == 0) ? 1 : h;
        if (sh >= sd) sh = sd - 1;
        s_div = sd; s_high = sh; m_pend = 1;
      end else if (start) begin
        m_pend = 0;
      end
      if (clr) m_cnt = 0;
      else if (start) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      x.cnt = CNT_W'(m_cnt);
      x.pend = m_pend;
    end
    sb.push_back(x);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t w, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        w = sb.pop_front();
        g = {clk_out, rise_pulse, rising_edge_count, cfg_pending};
        checks++;
        if (g !== w) begin
          failures++;
          $display("FAIL cycle%0d outputs: got clk_out=%b rise=%b count=%0d pending=%b, want clk_out=%b rise=%b count=%0d pending=%b",
                   cyc, g.co, g.rise, g.cnt, g.pend, w.co, w.rise, w.cnt, w.pend);
        end
      end
    end
  end

  initial begin : driver
    repeat (3) step(0, 0, 0, 0, 0, 1);

    // 4/2 for ten periods
    step(0, 1, 4, 2, 0, 0);
    run(40, 1);
    @(posedge clk); #2;
    checks++;
    if (rising_edge_count !== 4'd10) begin
      failures++;
      $display("FAIL count_after_10_periods: got %0d want 10", rising_edge_count);
    end

    // reconfigure to 6/3 at phase 1 of a 4/2 period
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 6, 3, 0, 0);
    run(16, 1);

    // 8/4 then en drop; output must finish the period and go idle
    step(1, 1, 8, 4, 0, 0);
    run(19, 1);
    run(14, 0);

    // degenerate config sanitised to 2/1, pending held while idle
    step(0, 1, 1, 0, 0, 0);
    run(3, 0);
    run(34, 1);
    step(1, 0, 0, 0, 1, 0);
    run(3, 1);
    step(1, 0, 0, 0, 1, 0);
    run(4, 1);

    // reset mid high phase, then restart on defaults
    step(1, 1, 8, 4, 0, 0);
    run(11, 1);
    step(1, 0, 0, 0, 0, 1);
    run(2, 0);
    run(6, 1);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) < 90, $urandom_range(99) < 6,
           int'($urandom_range(10)), int'($urandom_range(11)),
           $urandom_range(99) < 4, $urandom_range(199) == 0);
    end

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
